// File: rtl/rng_wb_pkg.sv
// Shared definitions for the RNG Wishbone initiator: responder register map,
// FSM state encoding, latched configuration payload and config-word selector.
package rng_wb_pkg;

    localparam int unsigned WB_AW     = 32;
    localparam int unsigned WB_DW     = 32;
    localparam int unsigned CFG_WORDS = 6;
    localparam int unsigned IDX_W     = 3;

    localparam logic [WB_AW-1:0] RNG_ADR_OUT     = 32'd0;
    localparam logic [WB_AW-1:0] RNG_ADR_SEED_HI = 32'd1;
    localparam logic [WB_AW-1:0] RNG_ADR_SEED_LO = 32'd2;
    localparam logic [WB_AW-1:0] RNG_ADR_MULT_HI = 32'd3;
    localparam logic [WB_AW-1:0] RNG_ADR_MULT_LO = 32'd4;
    localparam logic [WB_AW-1:0] RNG_ADR_INC_HI  = 32'd5;
    localparam logic [WB_AW-1:0] RNG_ADR_INC_LO  = 32'd6;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_REQ,
        ST_READ_REQ,
        ST_GAP,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic [63:0] seed;
        logic [63:0] mult;
        logic [63:0] inc;
    } rng_cfg_t;

    // Config word written at register (idx + 1): hi word of each value first.
    function automatic logic [WB_DW-1:0] cfg_word(input rng_cfg_t cfg,
                                                  input logic [IDX_W-1:0] idx);
        logic [WB_DW-1:0] w;
        case (idx)
            3'd0:    w = cfg.seed[63:32];
            3'd1:    w = cfg.seed[31:0];
            3'd2:    w = cfg.mult[63:32];
            3'd3:    w = cfg.mult[31:0];
            3'd4:    w = cfg.inc[63:32];
            3'd5:    w = cfg.inc[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rng_stream_fifo.sv
// Synchronous FIFO buffering random words between the bus side and the consumer.
// Ports: clk, rst (sync, active high), push_i/push_data_i, pop_i/pop_data_o,
//        full_o, empty_o, count_o (occupancy, 0..DEPTH).
module rng_stream_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/rng_wb_master.sv
// Wishbone classic initiator for the PCG-style RNG responder. On start it
// optionally writes seed/mult/inc (six words at adr 1..6), then reads adr 0
// back to back (stb, ack, gap) and streams the words out through a FIFO.
// Ports: clk, rst (sync, active high); session control start/stop/cfg_*;
//        stream rnd_data/rnd_valid/rnd_ready; status busy/err;
//        Wishbone master wbm_* (all outputs registered).
// Optional: define RNG_MASTER_TIMEOUT_EN to abort a request that is not
//           acknowledged within ACK_TIMEOUT cycles and raise sticky err.
module rng_wb_master
    import rng_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_load,
    input  logic [63:0]       cfg_seed,
    input  logic [63:0]       cfg_mult,
    input  logic [63:0]       cfg_inc,
    output logic [WB_DW-1:0]  rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy,
    output logic              err,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [WB_AW-1:0]  wbm_adr_o,
    output logic [WB_DW-1:0]  wbm_dat_o,
    input  logic [WB_DW-1:0]  wbm_dat_i,
    input  logic              wbm_ack_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || ACK_TIMEOUT < 1) begin : g_bad_param
        $error("rng_wb_master: illegal FIFO_DEPTH or ACK_TIMEOUT");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    rng_cfg_t           cfg_q, cfg_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [WB_AW-1:0]   adr_q, adr_d;
    logic [WB_DW-1:0]   dat_q, dat_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               push_c;
    logic               pop_c;
    logic               slot_free_c;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

`ifdef RNG_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

    assign pop_c       = rnd_ready && !fifo_empty;
    assign slot_free_c = (fifo_count < CNT_W'(FIFO_DEPTH));

    rng_stream_fifo #(
        .WIDTH (WB_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_c),
        .push_data_i (wbm_dat_i),
        .pop_i       (pop_c),
        .pop_data_o  (rnd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Next state, then Wishbone outputs derived from the state being entered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        push_c  = 1'b0;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = 4'h0;
        adr_d   = '0;
        dat_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d = '{seed: cfg_seed, mult: cfg_mult, inc: cfg_inc};
                    err_d = 1'b0;
                    if (cfg_load) begin
                        idx_d   = '0;
                        state_d = ST_CFG_REQ;
                    end else begin
                        idx_d   = IDX_W'(CFG_WORDS);
                        state_d = ST_READ_REQ;
                    end
                end
            end
            ST_CFG_REQ: begin
                if (wbm_ack_i) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_GAP;
                end
            end
            ST_READ_REQ: begin
                if (wbm_ack_i) begin
                    push_c  = !fifo_full;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Trailing ack from the responder lands here and is ignored.
                if (stop)                            state_d = ST_IDLE;
                else if (idx_q < IDX_W'(CFG_WORDS))  state_d = ST_CFG_REQ;
                else if (slot_free_c)                state_d = ST_READ_REQ;
                else                                 state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (stop)             state_d = ST_IDLE;
                else if (slot_free_c) state_d = ST_READ_REQ;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef RNG_MASTER_TIMEOUT_EN
        // Counts stb cycles without ack; abort the request on expiry.
        tmo_d = '0;
        if ((state_q == ST_CFG_REQ || state_q == ST_READ_REQ) && !wbm_ack_i) begin
            if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`else
        err_d = 1'b0;
`endif

        case (state_d)
            ST_CFG_REQ: begin
                cyc_d = 1'b1;
                stb_d = 1'b1;
                we_d  = 1'b1;
                sel_d = WB_SEL_ALL;
                adr_d = RNG_ADR_SEED_HI + WB_AW'(idx_d);
                dat_d = cfg_word(cfg_d, idx_d);
            end
            ST_READ_REQ: begin
                cyc_d = 1'b1;
                stb_d = 1'b1;
                sel_d = WB_SEL_ALL;
                adr_d = RNG_ADR_OUT;
            end
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cfg_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef RNG_MASTER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cfg_q   <= cfg_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef RNG_MASTER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign rnd_valid = !fifo_empty;

endmodule
